// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: CPU/host request channels, shared read data and RAM port bundle.
// Ports (slave = arbiter side):
//   cpu_req/cpu_we/cpu_addr/cpu_wdata -> arbiter, cpu_ack <- arbiter
//   host_req/host_we/host_addr/host_wdata -> arbiter, host_ack <- arbiter
//   rdata, owner <- arbiter; address_ram/data_ram/wren_ram <- arbiter; q_ram -> arbiter
interface ram_port_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_ack;
    logic        host_req;
    logic        host_we;
    logic [15:0] host_addr;
    logic [15:0] host_wdata;
    logic        host_ack;
    logic [15:0] rdata;
    logic [15:0] address_ram;
    logic [15:0] data_ram;
    logic        wren_ram;
    logic [15:0] q_ram;
    logic        owner;
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  host_req, host_we, host_addr, host_wdata, q_ram,
        output cpu_ack, host_ack, rdata, address_ram, data_ram, wren_ram, owner
    );
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output host_req, host_we, host_addr, host_wdata, q_ram,
        input  cpu_ack, host_ack, rdata, address_ram, data_ram, wren_ram, owner
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: two-requester (CPU, host) arbiter for a single-port RAM.
// Ports: clock (rising edge), reset (async, active-high), bus (ram_port_arbiter_if.slave).
// Parameter READ_LATENCY (1..7): clocks from address_ram change to valid q_ram.
// Macro RAM_ARB_RR_EN: round-robin on simultaneous requests; otherwise CPU has fixed priority.
module ram_port_arbiter #(
    parameter int READ_LATENCY = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    ram_port_arbiter_if.slave      bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;
    localparam logic [2:0] CNT_LOAD = 3'(READ_LATENCY - 1);
    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        cpu_ack_q, cpu_ack_d;
    logic        host_ack_q, host_ack_d;
    logic        wren_q, wren_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic [15:0] rdata_q, rdata_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        win_host;
`ifdef RAM_ARB_RR_EN
    // On a tie the grant goes to whoever did not own the RAM last.
    assign win_host = bus.host_req & (~bus.cpu_req | ~owner_q);
`else
    assign win_host = bus.host_req & ~bus.cpu_req;
`endif
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            cpu_ack_q  <= 1'b0;
            host_ack_q <= 1'b0;
            wren_q     <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            rdata_q    <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            cpu_ack_q  <= cpu_ack_d;
            host_ack_q <= host_ack_d;
            wren_q     <= wren_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rdata_q    <= rdata_d;
            cnt_q      <= cnt_d;
        end
    end
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        cpu_ack_d  = 1'b0;
        host_ack_d = 1'b0;
        wren_d     = wren_q;
        addr_d     = addr_q;
        data_d     = data_q;
        rdata_d    = rdata_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: begin
                wren_d = 1'b0;
                if (bus.cpu_req | bus.host_req) begin
                    owner_d = win_host;
                    addr_d  = win_host ? bus.host_addr  : bus.cpu_addr;
                    data_d  = win_host ? bus.host_wdata : bus.cpu_wdata;
                    wren_d  = win_host ? bus.host_we    : bus.cpu_we;
                    cnt_d   = CNT_LOAD;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // wren_q doubles as the write/read flag of the access in flight.
                if (wren_q || cnt_q == 3'd0) begin
                    wren_d     = 1'b0;
                    cpu_ack_d  = ~owner_q;
                    host_ack_d = owner_q;
                    rdata_d    = wren_q ? rdata_q : bus.q_ram;
                    state_d    = ACK;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    assign bus.cpu_ack     = cpu_ack_q;
    assign bus.host_ack    = host_ack_q;
    assign bus.owner       = owner_q;
    assign bus.wren_ram    = wren_q;
    assign bus.address_ram = addr_q;
    assign bus.data_ram    = data_q;
    assign bus.rdata       = rdata_q;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed checks of ram_port_arbiter with RAM models of latency 2 and 4.
module tb_ram_port_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;
    always #5 clock = ~clock;
    ram_port_arbiter_if b0();
    ram_port_arbiter_if b1();
    ram_port_arbiter #(.READ_LATENCY(2)) dut0 (.clock(clock), .reset(reset), .bus(b0));
    ram_port_arbiter #(.READ_LATENCY(4)) dut1 (.clock(clock), .reset(reset), .bus(b1));
    logic [15:0] mem0 [0:255];
    logic [15:0] p0;
    always @(posedge clock) begin
        if (b0.wren_ram) mem0[b0.address_ram[7:0]] <= b0.data_ram;
        p0 <= mem0[b0.address_ram[7:0]];
    end
    assign b0.q_ram = p0;
    logic [15:0] mem1 [0:255];
    logic [15:0] p1 [0:2];
    always @(posedge clock) begin
        p1[0] <= mem1[b1.address_ram[7:0]];
        p1[1] <= p1[0];
        p1[2] <= p1[1];
    end
    assign b1.q_ram = p1[2];
    task automatic wait_ack(input bit use1, input bit host, input int max, output int edges);
        edges = 0;
        while (edges <= max) begin
            @(negedge clock);
            edges++;
            if (use1 ? (host ? b1.host_ack : b1.cpu_ack) : (host ? b0.host_ack : b0.cpu_ack)) break;
        end
    endtask
    task automatic test_reset;
        #1;
        tests++; if (b0.wren_ram !== 1'b0) begin fails++; $display("FAIL rst_wren got %b want 0", b0.wren_ram); end
        tests++; if (b0.cpu_ack !== 1'b0) begin fails++; $display("FAIL rst_cpu_ack got %b want 0", b0.cpu_ack); end
        tests++; if (b0.host_ack !== 1'b0) begin fails++; $display("FAIL rst_host_ack got %b want 0", b0.host_ack); end
        tests++; if (b0.owner !== 1'b0) begin fails++; $display("FAIL rst_owner got %b want 0", b0.owner); end
        tests++; if (b0.rdata !== 16'h0) begin fails++; $display("FAIL rst_rdata got %h want 0000", b0.rdata); end
        tests++; if (b0.address_ram !== 16'h0) begin fails++; $display("FAIL rst_addr got %h want 0000", b0.address_ram); end
        tests++; if (b0.data_ram !== 16'h0) begin fails++; $display("FAIL rst_data got %h want 0000", b0.data_ram); end
        @(negedge clock);
        reset = 1'b0;
    endtask
    task automatic test_cpu_write;
        b0.cpu_req = 1'b1; b0.cpu_we = 1'b1; b0.cpu_addr = 16'h0010; b0.cpu_wdata = 16'hBEEF;
        @(negedge clock);
        tests++; if (b0.wren_ram !== 1'b1) begin fails++; $display("FAIL wr_wren_e1 got %b want 1", b0.wren_ram); end
        tests++; if (b0.address_ram !== 16'h0010) begin fails++; $display("FAIL wr_addr got %h want 0010", b0.address_ram); end
        tests++; if (b0.data_ram !== 16'hBEEF) begin fails++; $display("FAIL wr_data got %h want beef", b0.data_ram); end
        tests++; if (b0.cpu_ack !== 1'b0) begin fails++; $display("FAIL wr_ack_e1 got %b want 0", b0.cpu_ack); end
        @(negedge clock);
        tests++; if (b0.wren_ram !== 1'b0) begin fails++; $display("FAIL wr_wren_e2 got %b want 0", b0.wren_ram); end
        tests++; if (b0.cpu_ack !== 1'b1) begin fails++; $display("FAIL wr_ack_e2 got %b want 1", b0.cpu_ack); end
        b0.cpu_req = 1'b0;
        @(negedge clock);
        tests++; if (b0.cpu_ack !== 1'b0) begin fails++; $display("FAIL wr_ack_e3 got %b want 0", b0.cpu_ack); end
    endtask
    task automatic test_host_read;
        int e;
        b0.host_req = 1'b1; b0.host_we = 1'b0; b0.host_addr = 16'h0010;
        wait_ack(1'b0, 1'b1, 8, e);
        tests++; if (e !== 3) begin fails++; $display("FAIL hrd_latency got %0d want 3", e); end
        tests++; if (b0.rdata !== 16'hBEEF) begin fails++; $display("FAIL hrd_rdata got %h want beef", b0.rdata); end
        tests++; if (b0.owner !== 1'b1) begin fails++; $display("FAIL hrd_owner got %b want 1", b0.owner); end
        tests++; if (b0.cpu_ack !== 1'b0) begin fails++; $display("FAIL hrd_cpu_ack got %b want 0", b0.cpu_ack); end
        b0.host_req = 1'b0;
        @(negedge clock);
        tests++; if (b0.address_ram !== 16'h0010) begin fails++; $display("FAIL hrd_addr_hold got %h want 0010", b0.address_ram); end
        tests++; if (b0.rdata !== 16'hBEEF) begin fails++; $display("FAIL hrd_rdata_hold got %h want beef", b0.rdata); end
    endtask
    task automatic test_priority;
        int ca = 0;
        int ha = 0;
        int last = -1;
        b0.cpu_req = 1'b1; b0.cpu_we = 1'b0; b0.cpu_addr = 16'h0010;
        b0.host_req = 1'b1; b0.host_we = 1'b0; b0.host_addr = 16'h0077;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            tests++; if (b0.cpu_ack && b0.host_ack) begin fails++; $display("FAIL pri_both_ack cycle %0d got 11 want not both", i); end
            if (b0.cpu_ack) ca++;
            if (b0.host_ack) ha++;
`ifdef RAM_ARB_RR_EN
            if (b0.cpu_ack || b0.host_ack) begin
                tests++; if (last == int'(b0.host_ack)) begin fails++; $display("FAIL pri_rr_alt cycle %0d got repeat of %0d want alternation", i, last); end
                last = int'(b0.host_ack);
            end
`else
            tests++; if (b0.address_ram === 16'h0077) begin fails++; $display("FAIL pri_loser_addr cycle %0d got %h want not 0077", i, b0.address_ram); end
`endif
        end
`ifndef RAM_ARB_RR_EN
        tests++; if (ha !== 0) begin fails++; $display("FAIL pri_host_acks got %0d want 0", ha); end
        tests++; if (ca !== 3) begin fails++; $display("FAIL pri_cpu_acks got %0d want 3", ca); end
`else
        tests++; if (ca + ha !== 3) begin fails++; $display("FAIL pri_total_acks got %0d want 3", ca + ha); end
`endif
        b0.cpu_req = 1'b0; b0.host_req = 1'b0;
        @(negedge clock);
    endtask
    task automatic test_reset_mid;
        int e;
        b0.cpu_req = 1'b1; b0.cpu_we = 1'b0; b0.cpu_addr = 16'h0003;
        @(negedge clock);
        tests++; if (b0.address_ram !== 16'h0003) begin fails++; $display("FAIL rm_addr_pre got %h want 0003", b0.address_ram); end
        reset = 1'b1;
        #1;
        tests++; if (b0.address_ram !== 16'h0) begin fails++; $display("FAIL rm_addr got %h want 0000", b0.address_ram); end
        tests++; if (b0.rdata !== 16'h0) begin fails++; $display("FAIL rm_rdata got %h want 0000", b0.rdata); end
        tests++; if (b0.owner !== 1'b0) begin fails++; $display("FAIL rm_owner got %b want 0", b0.owner); end
        b0.cpu_req = 1'b0;
        @(negedge clock);
        tests++; if (b0.cpu_ack !== 1'b0 || b0.host_ack !== 1'b0) begin fails++; $display("FAIL rm_no_ack got %b%b want 00", b0.cpu_ack, b0.host_ack); end
        reset = 1'b0;
        b0.cpu_req = 1'b1; b0.cpu_we = 1'b1; b0.cpu_addr = 16'h0020; b0.cpu_wdata = 16'h5A5A;
        wait_ack(1'b0, 1'b0, 8, e);
        tests++; if (e !== 2) begin fails++; $display("FAIL rm_after_latency got %0d want 2", e); end
        tests++; if (b0.data_ram !== 16'h5A5A) begin fails++; $display("FAIL rm_after_data got %h want 5a5a", b0.data_ram); end
        b0.cpu_req = 1'b0;
        @(negedge clock);
        tests++; if (mem0[8'h20] !== 16'h5A5A) begin fails++; $display("FAIL rm_after_mem got %h want 5a5a", mem0[8'h20]); end
    endtask
    task automatic test_latency4;
        int e;
        b1.cpu_req = 1'b1; b1.cpu_we = 1'b0; b1.cpu_addr = 16'h0003;
        wait_ack(1'b1, 1'b0, 12, e);
        tests++; if (e !== 5) begin fails++; $display("FAIL rl4_latency got %0d want 5", e); end
        tests++; if (b1.rdata !== 16'h1234) begin fails++; $display("FAIL rl4_rdata got %h want 1234", b1.rdata); end
        b1.cpu_req = 1'b0;
        @(negedge clock);
    endtask
    initial begin
        mem1[3] = 16'h1234;
        b0.cpu_req = 0; b0.cpu_we = 0; b0.cpu_addr = 0; b0.cpu_wdata = 0;
        b0.host_req = 0; b0.host_we = 0; b0.host_addr = 0; b0.host_wdata = 0;
        b1.cpu_req = 0; b1.cpu_we = 0; b1.cpu_addr = 0; b1.cpu_wdata = 0;
        b1.host_req = 0; b1.host_we = 0; b1.host_addr = 0; b1.host_wdata = 0;
        test_reset();
        test_cpu_write();
        test_host_read();
        test_priority();
        test_reset_mid();
        test_latency4();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
